// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: assembles big-endian 32-bit words from a byte
// stream, writes them to consecutive word addresses and holds the CPU meanwhile.
module inst_mem_loader #(
  parameter int unsigned         ADDR_W    = 6,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W:0]   Load_Len,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  output logic              Mem_WE,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       Checksum
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wcnt;
  logic [31:0]     word_q;
  logic            byte_xfer;
  logic            start_load;
  logic            last_word;

  // A load can never exceed the memory depth.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  assign byte_xfer  = Byte_Valid && Byte_Ready;
  assign start_load = (state == S_IDLE) && Start && (Load_Len != '0);
  assign last_word  = ((wcnt + (ADDR_W+1)'(1)) == len_q);
  assign Mem_WData  = word_q;

  always_ff @(posedge Clk) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Byte_Ready = 1'b0;
    Mem_WE     = 1'b0;
    Cpu_Hold   = 1'b0;
    Busy       = 1'b1;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) state_nxt = (Load_Len == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        Byte_Ready = 1'b1;
        Cpu_Hold   = 1'b1;
        if (Byte_Valid && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        Mem_WE    = 1'b1;
        Cpu_Hold  = 1'b1;
        state_nxt = last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word assembly, address walk and running checksum.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      byte_cnt <= '0;
      len_q    <= '0;
      wcnt     <= '0;
      word_q   <= '0;
      Mem_Addr <= BASE_ADDR;
      Checksum <= '0;
    end else begin
      if (start_load) begin
        len_q    <= clamp_len(Load_Len);
        wcnt     <= '0;
        byte_cnt <= '0;
        Mem_Addr <= BASE_ADDR;
        Checksum <= '0;
      end
      if (byte_xfer) begin
        word_q   <= {word_q[23:0], Byte_In};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == S_WRITE) begin
        Checksum <= Checksum ^ word_q;
        wcnt     <= wcnt + (ADDR_W+1)'(1);
        // Address stays on the last written word once the load finishes.
        if (!last_word) Mem_Addr <= Mem_Addr + ADDR_W'(1);
      end
    end
  end

endmodule
